// File: rtl/bus_select_arbiter.sv
// N-channel bus arbiter: req/ack handshake, encoded bus_select, bus_switch disable,
// fixed-priority or round-robin selection, bounded hold with preemption.
module bus_select_arbiter #(
  parameter int N_CH     = 4,
  parameter int SEL_W    = $clog2(N_CH),
  parameter int MODE     = 0,
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   req,
  input  logic              bus_switch,
  output logic [N_CH-1:0]   ack,
  output logic [SEL_W-1:0]  bus_select,
  output logic              bus_busy,
  output logic              preempt
);

  // Handshake: a channel holds req high for as long as it wants the bus; ack is
  // the registered grant and the owner keeps the bus until its req is seen low
  // (or a hold timeout preempts it). Every change of owner passes through one
  // cycle with ack == 0.

  typedef enum logic [1:0] {IDLE, GRANT, SWITCH} state_t;

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   owner;
  logic [SEL_W-1:0]   last_owner;
  logic [CNT_W-1:0]   hold_cnt;
  logic               excl_vld;
  logic [SEL_W-1:0]   excl_idx;

  logic [N_CH-1:0]    eligible;
  logic               win_vld;
  logic [SEL_W-1:0]   win_idx;
  logic               do_grant;
  logic               do_preempt;
  logic               others_waiting;
  logic               hold_expired;
  int                 cand;

  // The channel preempted last cycle sits out exactly one arbitration.
  always_comb begin
    eligible = req;
    if (excl_vld) eligible[excl_idx] = 1'b0;
  end

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (MODE == 1) cand = (int'(last_owner) + 1 + i) % N_CH;
      else           cand = i;
      if (!win_vld && eligible[cand]) begin
        win_vld = 1'b1;
        win_idx = SEL_W'(cand);
      end
    end
  end

  assign others_waiting = |(req & ~ack);
  assign hold_expired   = (HOLD_MAX != 0) && (hold_cnt == CNT_W'(HOLD_MAX));

  always_comb begin
    state_nxt  = state;
    do_grant   = 1'b0;
    do_preempt = 1'b0;
    if (bus_switch) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            state_nxt = GRANT;
            do_grant  = 1'b1;
          end
        end
        GRANT: begin
          // A release at the timeout edge counts as a plain release.
          if (!req[owner]) begin
            state_nxt = SWITCH;
          end else if (hold_expired && others_waiting) begin
            state_nxt  = SWITCH;
            do_preempt = 1'b1;
          end
        end
        SWITCH: begin
          if (win_vld) begin
            state_nxt = GRANT;
            do_grant  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack        <= '0;
      owner      <= '0;
      last_owner <= SEL_W'(N_CH - 1);
      hold_cnt   <= '0;
      preempt    <= 1'b0;
      excl_vld   <= 1'b0;
      excl_idx   <= '0;
    end else begin
      state    <= state_nxt;
      preempt  <= do_preempt;
      excl_vld <= do_preempt;
      excl_idx <= owner;
      if (do_grant) begin
        ack        <= {{(N_CH-1){1'b0}}, 1'b1} << win_idx;
        owner      <= win_idx;
        last_owner <= win_idx;
        hold_cnt   <= CNT_W'(1);
      end else if (state_nxt == GRANT) begin
        if (hold_cnt != {CNT_W{1'b1}}) hold_cnt <= hold_cnt + CNT_W'(1);
      end else begin
        ack      <= '0;
        owner    <= '0;
        hold_cnt <= '0;
      end
    end
  end

  assign bus_select = owner;
  assign bus_busy   = |ack;

endmodule

// File: tb/tb_bus_select_arbiter.sv
// Directed bench for bus_select_arbiter: table of fixed-priority vectors plus
// hand-written round-robin, preemption, bus_switch, async reset and random phases.
module tb_bus_select_arbiter;

  logic clk;
  logic rst_n;

  // dut0: MODE 0, HOLD_MAX 15 ; dut1: MODE 1, HOLD_MAX 15 ; dut2: MODE 0, HOLD_MAX 4
  logic [3:0] req0, req1, req2;
  logic       bs0, bs1, bs2;
  logic [3:0] ack0, ack1, ack2;
  logic [1:0] sel0, sel1, sel2;
  logic       busy0, busy1, busy2;
  logic       pre0, pre1, pre2;

  int vectors;
  int miscompares;

  bus_select_arbiter #(.N_CH(4), .MODE(0), .HOLD_MAX(15), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .bus_switch(bs0),
    .ack(ack0), .bus_select(sel0), .bus_busy(busy0), .preempt(pre0));
  bus_select_arbiter #(.N_CH(4), .MODE(1), .HOLD_MAX(15), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .bus_switch(bs1),
    .ack(ack1), .bus_select(sel1), .bus_busy(busy1), .preempt(pre1));
  bus_select_arbiter #(.N_CH(4), .MODE(0), .HOLD_MAX(4), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .bus_switch(bs2),
    .ack(ack2), .bus_select(sel2), .bus_busy(busy2), .preempt(pre2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  a_onehot1: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack1))
    else $error("ack1 not onehot0");
  a_onehot2: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack2))
    else $error("ack2 not onehot0");

  typedef struct {
    logic [3:0] req;
    logic       bs;
    logic [3:0] ack;
    logic [1:0] sel;
    logic       busy;
    logic       pre;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] a);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (a[i]) r = 2'(i);
    return r;
  endfunction

  task automatic chk_props(input string name, input logic [3:0] a, input logic [1:0] s,
                           input logic b, input logic [3:0] prev);
    logic ok;
    ok = $onehot0(a) && (s == idx_of(a)) && (b == (a != 4'b0)) &&
         !((prev != 4'b0) && (a != 4'b0) && (a != prev));
    chk(name, {29'd0, ok, 2'b00} | {31'd0, ok}, {29'd0, 1'b1, 2'b00} | 32'd1);
  endtask

  logic [3:0] prev1, prev2;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req0 = '0; req1 = '0; req2 = '0;
    bs0 = 1'b0; bs1 = 1'b0; bs2 = 1'b0;

    //               req      bs    ack      sel busy pre
    tbl[0]  = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[1]  = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    tbl[2]  = '{4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[4]  = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[6]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[7]  = '{4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[9]  = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[10] = '{4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[11] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[14] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack", 32'(ack0), 32'd0);
    chk("reset_sel", 32'(sel0), 32'd0);
    chk("reset_busy", 32'(busy0), 32'd0);
    chk("reset_pre", 32'(pre0), 32'd0);
    rst_n = 1'b1;

    // table: fixed priority
    for (int v = 0; v < 15; v++) begin
      req0 = tbl[v].req;
      bs0  = tbl[v].bs;
      step();
      chk($sformatf("tbl%0d_ack", v),  32'(ack0),  32'(tbl[v].ack));
      chk($sformatf("tbl%0d_sel", v),  32'(sel0),  32'(tbl[v].sel));
      chk($sformatf("tbl%0d_busy", v), 32'(busy0), 32'(tbl[v].busy));
      chk($sformatf("tbl%0d_pre", v),  32'(pre0),  32'(tbl[v].pre));
    end
    req0 = '0;

    // preemption, HOLD_MAX = 4
    req2 = 4'b0001;
    step(); chk("pm_g1", 32'(ack2), 32'h1);
    step(); chk("pm_g2", 32'(ack2), 32'h1);
    req2 = 4'b0101;
    step(); chk("pm_g3", 32'(ack2), 32'h1); chk("pm_g3_pre", 32'(pre2), 32'd0);
    step(); chk("pm_g4", 32'(ack2), 32'h1); chk("pm_g4_pre", 32'(pre2), 32'd0);
    step(); chk("pm_cut_ack", 32'(ack2), 32'h0); chk("pm_cut_pre", 32'(pre2), 32'd1);
    step(); chk("pm_new_ack", 32'(ack2), 32'h4); chk("pm_new_sel", 32'(sel2), 32'd2);
    chk("pm_new_pre", 32'(pre2), 32'd0);
    step(); chk("pm_hold2", 32'(ack2), 32'h4);
    req2 = 4'b0001;
    step(); chk("pm_rel", 32'(ack2), 32'h0);
    step(); chk("pm_regrant", 32'(ack2), 32'h1); chk("pm_regrant_sel", 32'(sel2), 32'd0);
    req2 = '0;

    // round robin, each owner drops req for one cycle after 3 grant cycles
    req1 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        chk($sformatf("rr%0d_ack", k), 32'(ack1), 32'(4'b0001 << (k % 4)));
        chk($sformatf("rr%0d_sel", k), 32'(sel1), 32'(k % 4));
      end
      req1[k % 4] = 1'b0;
      step();
      chk($sformatf("rr%0d_gap", k), 32'(ack1), 32'd0);
      req1 = 4'b1111;
    end

    // bus_switch during a channel 3 grant
    req1 = 4'b1000;
    step(); chk("bs_pre_ack", 32'(ack1), 32'h8);
    bs1 = 1'b1;
    step(); chk("bs_ack", 32'(ack1), 32'h0); chk("bs_busy", 32'(busy1), 32'd0);
    step(); chk("bs_hold1", 32'(ack1), 32'h0);
    step(); chk("bs_hold2", 32'(ack1), 32'h0);
    bs1 = 1'b0;
    step(); chk("bs_regrant", 32'(ack1), 32'h8); chk("bs_regrant_sel", 32'(sel1), 32'd3);

    // asynchronous reset mid-grant
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(ack1), 32'd0);
    chk("arst_sel", 32'(sel1), 32'd0);
    chk("arst_busy", 32'(busy1), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    req1 = 4'b1111;
    step(); chk("arst_first", 32'(ack1), 32'h1);

    // random phase
    prev1 = ack1;
    prev2 = ack2;
    for (int n = 0; n < 10000; n++) begin
      req1 = 4'($urandom_range(0, 15));
      req2 = 4'($urandom_range(0, 15));
      bs1  = ($urandom_range(0, 31) == 0);
      bs2  = ($urandom_range(0, 31) == 0);
      step();
      chk_props("rand1", ack1, sel1, busy1, prev1);
      chk_props("rand2", ack2, sel2, busy2, prev2);
      prev1 = ack1;
      prev2 = ack2;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
